multdiv: RTL
============

MULTDIV -- requirements
Module: multdiv

Interface
REQ-001 SHALL have port: clock  input  1  single clock; all state updates on the rising edge.
REQ-002 SHALL have port: ctrl_reset  input  1  reset, asynchronous and active-low.
REQ-003 SHALL have port: data_operandA  input  32  signed two's-complement operand A (multiplicand / dividend), from register file read port A.
REQ-004 SHALL have port: data_operandB  input  32  signed two's-complement operand B (multiplier / divisor), from register file read port B.
REQ-005 SHALL have port: ctrl_MULT  input  1  start-multiply pulse, sampled on the rising edge.
REQ-006 SHALL have port: ctrl_DIV  input  1  start-divide pulse, sampled on the rising edge.
REQ-007 SHALL have port: data_result  output  32  registered result, destined for the register file write port.
REQ-008 SHALL have port: data_exception  output  1  registered overflow / divide-by-zero flag, valid with data_result.
REQ-009 SHALL have port: data_resultRDY  output  1  one-cycle completion pulse.
REQ-010 SHALL have port: busy  output  1  high while an operation is in flight.

Function
REQ-011 SHALL implement the states IDLE, MULT, DIV and DONE in a state register of at most 2 bits, plus a 6-bit iteration counter.
REQ-012 Start edge: ctrl_MULT=1 at an edge SHALL latch both operands, clear the counter and enter MULT; ctrl_DIV=1 (with ctrl_MULT=0) SHALL do the same and enter DIV.
REQ-013 ctrl_MULT and ctrl_DIV both high at the same edge SHALL start a multiply; ctrl_MULT has priority.
REQ-014 MULT SHALL perform one radix-2 Booth step per cycle on a 65-bit product register, for exactly 32 iterations.
REQ-015 DIV SHALL perform one restoring step per cycle on operand magnitudes, for exactly 32 iterations.
REQ-016 DIV sign handling: quotient negated iff operand signs differ; quotient truncates toward zero; remainder is discarded.
REQ-017 After iteration 32 the block SHALL enter DONE, register data_result and data_exception, and assert data_resultRDY.
REQ-018 Latency: data_resultRDY SHALL be high for exactly one cycle, during the cycle after the 33rd rising edge following the start edge; it is identical for MULT and DIV.
REQ-019 DONE SHALL return to IDLE on the next edge; data_resultRDY SHALL then deassert.
REQ-020 Multiply result: data_result = low 32 bits of the 64-bit signed product.
REQ-021 Multiply exception: data_exception=1 iff the 64-bit product is not the sign-extension of its low 32 bits.
REQ-022 Divide by zero (operandB=0): data_result=0x00000000 and data_exception=1, with the full 33-cycle latency.
REQ-023 Divide of 0x80000000 by 0xFFFFFFFF: data_result=0x80000000 and data_exception=1.
REQ-024 Any other divide SHALL give data_exception=0.
REQ-025 data_result and data_exception SHALL hold their last completed values until the next completion.
REQ-026 busy SHALL be high in MULT, DIV and DONE, and low in IDLE.
REQ-027 A start pulse while busy=1 SHALL abort the current operation with no data_resultRDY, latch the new operands and restart the latency count from that edge.
REQ-028 Operand inputs SHALL be ignored except at start edges; they may change freely mid-operation.

Reset
REQ-029 ctrl_reset=0 SHALL immediately, independent of clock, force: state=IDLE, counter=0, data_result=0x00000000, data_exception=0, data_resultRDY=0, busy=0.
REQ-030 Reset asserted mid-operation SHALL discard that operation; no data_resultRDY SHALL follow release.
REQ-031 Start pulses while ctrl_reset=0 SHALL be ignored; the first start accepted is the first rising edge with ctrl_reset=1.

Verification
REQ-032 Multiply: A=7, B=0xFFFFFFFD (-3), ctrl_MULT pulse -> at start+33: data_resultRDY=1, data_result=0xFFFFFFEB, data_exception=0; busy high throughout.
REQ-033 Multiply overflow: A=0x00010000, B=0x00010000 -> data_result=0x00000000, data_exception=1.
REQ-034 Divide: A=0xFFFFFFF9 (-7), B=2 -> data_result=0xFFFFFFFD; then A=5, B=0 -> data_result=0, data_exception=1; then A=0x80000000, B=0xFFFFFFFF -> data_result=0x80000000, data_exception=1.
REQ-035 Restart and priority: ctrl_DIV with A=100, B=7; at start+10, ctrl_MULT with A=3, B=4 -> one data_resultRDY only, at second start+33, data_result=12; both strobes high in one cycle -> multiply result.
REQ-036 Reset mid-op: ctrl_MULT, then ctrl_reset=0 at start+15 between edges -> outputs zero immediately; no data_resultRDY for 40 cycles after release; busy=0.

Source files
------------

// File: rtl/multdiv.sv
// ============================================================================
// Module   : multdiv
// Purpose  : Iterative signed 32x32 multiplier (radix-2 Booth) and restoring
//            divider with a fixed 33-cycle start-to-ready latency.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multdiv (
    input  logic        clock,
    input  logic        ctrl_reset,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [5:0] C_LAST_ITER = 6'd32;

    state_t      state_q;
    logic [5:0]  cnt_q;
    logic [64:0] prod_q;
    logic [31:0] mcand_q;
    logic        neg_q;
    logic        dzero_q;
    logic [31:0] result_q;
    logic        exc_q;
    logic        rdy_q;

    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] acc_ext;
    logic [32:0] m_ext;
    logic [32:0] booth_sum;
    logic [64:0] booth_d;
    logic [32:0] div_shift;
    logic [33:0] div_sub;
    logic [31:0] div_rem;
    logic [64:0] div_d;
    logic [31:0] quo_signed;

    assign a_mag = data_operandA[31] ? (32'd0 - data_operandA) : data_operandA;
    assign b_mag = data_operandB[31] ? (32'd0 - data_operandB) : data_operandB;

    // Booth add is done at 33 bits so a multiplicand of -2^31 cannot overflow.
    always_comb begin
        acc_ext = {prod_q[64], prod_q[64:33]};
        m_ext   = {mcand_q[31], mcand_q};
        case (prod_q[1:0])
            2'b01:   booth_sum = acc_ext + m_ext;
            2'b10:   booth_sum = acc_ext - m_ext;
            default: booth_sum = acc_ext;
        endcase
        booth_d = {booth_sum, prod_q[32:1]};
    end

    // Restoring step: remainder in prod_q[63:32], dividend/quotient in [31:0].
    always_comb begin
        div_shift  = {prod_q[63:32], prod_q[31]};
        div_sub    = {1'b0, div_shift} - {2'b00, mcand_q};
        div_rem    = div_sub[33] ? div_shift[31:0] : div_sub[31:0];
        div_d      = {1'b0, div_rem, prod_q[30:0], ~div_sub[33]};
        quo_signed = neg_q ? (32'd0 - prod_q[31:0]) : prod_q[31:0];
    end

    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            state_q  <= IDLE;
            cnt_q    <= 6'd0;
            prod_q   <= 65'd0;
            mcand_q  <= 32'd0;
            neg_q    <= 1'b0;
            dzero_q  <= 1'b0;
            result_q <= 32'd0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            rdy_q <= 1'b0;
            if (ctrl_MULT) begin
                state_q <= MULT;
                cnt_q   <= 6'd0;
                prod_q  <= {32'd0, data_operandB, 1'b0};
                mcand_q <= data_operandA;
            end else if (ctrl_DIV) begin
                state_q <= DIV;
                cnt_q   <= 6'd0;
                prod_q  <= {33'd0, a_mag};
                mcand_q <= b_mag;
                neg_q   <= data_operandA[31] ^ data_operandB[31];
                dzero_q <= (data_operandB == 32'd0);
            end else begin
                case (state_q)
                    MULT: begin
                        if (cnt_q == C_LAST_ITER) begin
                            state_q  <= DONE;
                            rdy_q    <= 1'b1;
                            result_q <= prod_q[32:1];
                            exc_q    <= (prod_q[64:33] != {32{prod_q[32]}});
                        end else begin
                            prod_q <= booth_d;
                            cnt_q  <= cnt_q + 6'd1;
                        end
                    end
                    DIV: begin
                        if (cnt_q == C_LAST_ITER) begin
                            state_q  <= DONE;
                            rdy_q    <= 1'b1;
                            result_q <= dzero_q ? 32'd0 : quo_signed;
                            // Only -2^31 / -1 yields a positive 2^31 quotient.
                            exc_q    <= dzero_q || (!neg_q && prod_q[31:0] == 32'h8000_0000);
                        end else begin
                            prod_q <= div_d;
                            cnt_q  <= cnt_q + 6'd1;
                        end
                    end
                    DONE:    state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign busy           = (state_q != IDLE);

endmodule

`default_nettype wire
